// File: rtl/pulse_rx_buffer.sv
// pulse_rx_buffer
//   Destination-domain receiver for the single-cycle en/data strobes produced
//   by cdc_s2f_pulse. Strobes cannot be stalled, so they are caught in a small
//   FIFO and re-presented to the consumer as a valid/ready stream. A strobe that
//   arrives while the FIFO is full (and nothing leaves in the same edge) is
//   dropped, and the loss is recorded in a sticky flag and a saturating counter.
//
//   Handshake: the consumer takes the head word on any rising edge where
//   out_valid and out_ready are both high. out_ready while out_valid is low does
//   nothing. out_valid depends only on registered state, never on in_en.
//
// Ports:
//   clk        block clock (dest_clk of the synchronizer)
//   rst        asynchronous, active-high reset
//   in_en      strobe: in_data is valid this cycle
//   in_data    strobe payload, DW bits
//   out_valid  head entry available
//   out_ready  consumer accepts head entry when out_valid is high
//   out_data   head entry, read straight from registered storage
//   level      entries currently held, 0..DEPTH
//   overflow   sticky: at least one strobe was dropped
//   drop_cnt   saturating count of dropped strobes
//   clr_err    synchronous clear of overflow and drop_cnt
module pulse_rx_buffer #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          clr_err
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    // Storage and pointers. Pointers carry one extra wrap bit so that
    // wr_ptr - rd_ptr gives the fill level across any number of wraps.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    // Per-edge decode.
    logic [AW:0]   level_w;
    logic          full_w;
    logic          pop_w;
    logic          push_w;
    logic          drop_w;

    always_comb begin
        level_w = wr_ptr_q - rd_ptr_q;
        full_w  = (level_w == FULL_LEVEL);
        pop_w   = (level_w != '0) && out_ready;
        // A pop in the same edge frees the slot, so a full FIFO still
        // accepts the strobe in that case.
        push_w  = in_en && (!full_w || pop_w);
        drop_w  = in_en && full_w && !pop_w;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_w) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end

        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A drop in the same edge as clr_err wins: the record restarts at one.
        if (drop_w) begin
            overflow_d = 1'b1;
            if (clr_err) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clr_err) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Storage is cleared on reset so out_data reads 0 until the first strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = (level_w != '0);
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level     = level_w;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/pulse_rx_buffer.md
Name: pulse_rx_buffer

Overview:
- Receive-side companion to cdc_s2f_pulse, in the destination clock domain.
- Captures the single-cycle en/data strobes from the synchronizer. These strobes have no backpressure.
- Buffers them in a small FIFO and re-presents them to the downstream consumer as a valid/ready stream.
- Flags and counts any strobe lost to a full buffer, so the consumer never silently misses a word.

Parameters:
- DW, 32, data width of each strobe word.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  block clock; dest_clk of the upstream synchronizer.
- rst  input  1  asynchronous, active-high reset.
- in_en  input  1  single-cycle strobe: in_data is valid this cycle.
- in_data  input  DW  strobe payload.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry when out_valid is high.
- out_data  output  DW  head entry; registered FIFO storage.
- level  output  AW+1  entries currently held, 0..DEPTH.
- overflow  output  1  sticky flag: a strobe was dropped.
- drop_cnt  output  8  saturating count of dropped strobes.
- clr_err  input  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst high, asynchronous, any time): wr_ptr = rd_ptr = 0, level = 0, out_valid = 0, overflow = 0, drop_cnt = 0.
  - out_data is 0 after reset.
  - Storage contents are don't-care.
  - Reset mid-stream discards all held entries; the first strobe after rst deasserts is entry 0.
- Push: on a rising edge with in_en = 1 and the FIFO not full, in_data is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: on a rising edge with out_valid = 1 and out_ready = 1, rd_ptr increments modulo DEPTH.
- out_ready while out_valid = 0 has no effect.
- Full/empty: level is tracked by the pointers with one extra wrap bit (AW+1 bits). Full is level == DEPTH; empty is level == 0.
- Latency:
  - A strobe sampled at edge N into an empty FIFO gives out_valid = 1 and out_data = that word after edge N (visible in cycle N+1).
  - There is no combinational path from in_en to out_valid.
- out_valid = (level != 0). out_data always shows the entry at rd_ptr and stays stable while out_valid = 1 and out_ready = 0.
- Simultaneous push and pop in one edge:
  - level is unchanged.
  - Both pointers advance.
  - When full, the push is accepted because the pop frees the slot in the same edge; no drop.
- Drop: in_en = 1, FIFO full and no pop in the same edge.
  - The word is discarded.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 255.
  - FIFO contents and pointers are unchanged.
- clr_err = 1 clears overflow and drop_cnt at the edge. If a drop occurs in the same edge, the drop wins: overflow = 1 and drop_cnt = 1.
- Pointer wrap: pointers roll from DEPTH-1 to 0. The wrap bit toggles so level stays correct across any number of wraps.
- Ordering: words leave strictly in arrival order; there is no reordering or duplication.

Test Plan:
- Reset then single strobe: in_en pulse with in_data = 0x0000_0001, out_ready = 0 -> next cycle out_valid = 1, out_data = 0x1, level = 1. out_data holds 0x1 over 10 cycles; assert out_ready -> level = 0, out_valid = 0 next cycle.
- Burst of 15 strobes, every other cycle, data 0x1..0xF, out_ready tied 1 -> all 15 words appear in order 0x1..0xF, overflow = 0, drop_cnt = 0. Pointers wrap at least 3 times.
- Overflow: out_ready = 0, 6 strobes 0xA1..0xA6 with DEPTH = 4 -> level = 4, overflow = 1, drop_cnt = 2. Draining yields exactly 0xA1, 0xA2, 0xA3, 0xA4.
- Full with simultaneous push/pop: fill to 4 (0xB1..0xB4), then in the same cycle strobe 0xB5 with out_ready = 1 -> level stays 4, no drop. Drained order is 0xB2, 0xB3, 0xB4, 0xB5.
- clr_err: after the overflow case, pulse clr_err -> overflow = 0, drop_cnt = 0. Then clr_err coincident with a drop while full -> overflow = 1, drop_cnt = 1.
- Async reset mid-operation: level = 3, assert rst between clock edges -> out_valid, level and overflow go 0 immediately. After release, strobe 0xCC -> out_data = 0xCC as the sole entry.
